// File: rtl/sd_score_pkg.sv
// Shared types and constants for the SD high-score writer.
// The record layout lives here so the writer and any reader agree on it.
package sd_score_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_WAIT_PORT,
        S_START,
        S_WAIT_BUSY,
        S_STREAM,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [15:0] MAGIC     = 16'h4642;
    localparam int          SEC_WORDS = 256;
    localparam logic [8:0]  END_IDX   = 9'(SEC_WORDS);
    localparam logic [3:0]  CAP_LAST  = 4'd15;

    localparam logic [8:0] W_MAGIC    = 9'd0;
    localparam logic [8:0] W_SCORE_HI = 9'd1;
    localparam logic [8:0] W_SCORE_LO = 9'd2;
    localparam logic [8:0] W_CNT      = 9'd3;
    localparam logic [8:0] W_CHK      = 9'd4;

    // Word idx of the record sector; everything past the checksum is zero.
    function automatic logic [15:0] record_word(input logic [8:0]  idx,
                                                input logic [23:0] score,
                                                input logic [15:0] cnt);
        logic [15:0] w_hi;
        logic [15:0] w_lo;
        w_hi = {8'h00, score[23:16]};
        w_lo = score[15:0];
        case (idx)
            W_MAGIC:    return MAGIC;
            W_SCORE_HI: return w_hi;
            W_SCORE_LO: return w_lo;
            W_CNT:      return cnt;
            W_CHK:      return MAGIC ^ w_hi ^ w_lo ^ cnt;
            default:    return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/sd_score_sync.sv
// Brings game_state/score_bcd from the HDMI domain into clk_50m and
// flags the cycle on which the synchronized state enters OVER.
module sd_score_sync (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic [1:0]  i_game_state,
    input  logic [23:0] i_score_bcd,
    output logic [23:0] o_score,
    output logic        o_over_req
);

    logic [1:0]  r_gs_meta;
    logic [1:0]  r_gs_sync;
    logic [1:0]  r_gs_prev;
    logic [23:0] r_sc_meta;
    logic [23:0] r_sc_sync;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_gs_meta <= '0;
            r_gs_sync <= '0;
            r_gs_prev <= '0;
            r_sc_meta <= '0;
            r_sc_sync <= '0;
        end else begin
            r_gs_meta <= i_game_state;
            r_gs_sync <= r_gs_meta;
            r_gs_prev <= r_gs_sync;
            r_sc_meta <= i_score_bcd;
            r_sc_sync <= r_sc_meta;
        end
    end

    // Score bits may land on different cycles; the writer waits for it to settle.
    assign o_score    = r_sc_sync;
    assign o_over_req = (r_gs_sync == 2'd2) && (r_gs_prev != 2'd2);

endmodule

// File: rtl/sd_score_writer.sv
// Saves a new Flappy Bird high score as a one-sector record through the
// write port of sd_ctrl_top, with start/busy timeouts and length checking.
module sd_score_writer
    import sd_score_pkg::*;
#(
    parameter logic [31:0] SCORE_SEC_ADDR = 32'd32768,
    parameter int          START_TO       = 1000,
    parameter int          BUSY_TO        = 10_000_000
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic [1:0]  game_state,
    input  logic [23:0] score_bcd,
    input  logic        sd_init_done,
    input  logic        pic_load_done,
    input  logic        wr_busy,
    input  logic        wr_req,
    output logic        wr_start_en,
    output logic [31:0] wr_sec_addr,
    output logic [15:0] wr_data,
    output logic [23:0] hi_score_bcd,
    output logic        save_busy,
    output logic        save_done,
    output logic        save_err
);

    state_e      r_state;
    state_e      w_next;
    logic [23:0] w_score;
    logic        w_over_req;
    logic        w_cap_ready;
    logic        w_new_rec;

    logic [23:0] r_cap_prev;
    logic [3:0]  r_cap_cnt;
    logic [23:0] r_hi;
    logic [15:0] r_wcnt;
    logic [8:0]  r_idx;
    logic        r_ovr;
    logic [15:0] r_wr_data;
    logic [23:0] r_to_cnt;
    logic        r_err;

    sd_score_sync u_sync (
        .clk_50m      (clk_50m),
        .rst_n        (rst_n),
        .i_game_state (game_state),
        .i_score_bcd  (score_bcd),
        .o_score      (w_score),
        .o_over_req   (w_over_req)
    );

    // Two identical samples in a row, or give up and take the 16th.
    assign w_cap_ready = (w_score == r_cap_prev) || (r_cap_cnt == CAP_LAST);
    assign w_new_rec   = w_score > r_hi;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        wr_start_en = 1'b0;
        save_done   = 1'b0;
        save_busy   = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:      if (w_over_req) w_next = S_CAPTURE;
            S_CAPTURE:   if (w_cap_ready) w_next = w_new_rec ? S_WAIT_PORT : S_IDLE;
            S_WAIT_PORT: if (sd_init_done && pic_load_done && !wr_busy) w_next = S_START;
            S_START: begin
                wr_start_en = 1'b1;
                w_next      = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (wr_busy)                            w_next = S_STREAM;
                else if (r_to_cnt == 24'(START_TO - 1)) w_next = S_ERR;
            end
            S_STREAM: begin
                if (!wr_busy)
                    w_next = (r_idx == END_IDX && !r_ovr) ? S_DONE : S_ERR;
                else if (r_to_cnt == 24'(BUSY_TO - 1))
                    w_next = S_ERR;
            end
            S_DONE: begin
                save_done = 1'b1;
                w_next    = S_IDLE;
            end
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_prev <= '0;
            r_cap_cnt  <= '0;
            r_hi       <= '0;
            r_wcnt     <= '0;
            r_to_cnt   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_cap_prev <= w_score;
            r_cap_cnt  <= (r_state == S_CAPTURE) ? r_cap_cnt + 4'd1 : 4'd0;

            if (w_next != r_state)
                r_to_cnt <= '0;
            else if (r_state == S_WAIT_BUSY || r_state == S_STREAM)
                r_to_cnt <= r_to_cnt + 24'd1;

            // hi/write_cnt commit before the write; a failed write does not undo them.
            if (r_state == S_CAPTURE && w_next == S_WAIT_PORT) begin
                r_hi   <= w_score;
                r_wcnt <= r_wcnt + 16'd1;
            end

            if (r_state == S_IDLE && w_over_req)
                r_err <= 1'b0;
            else if (w_next == S_ERR && r_state != S_ERR)
                r_err <= 1'b1;
        end
    end

    // wr_data always holds the word the controller will take on its next wr_req.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_ovr     <= 1'b0;
            r_wr_data <= MAGIC;
        end else if (r_state == S_STREAM) begin
            if (wr_req) begin
                if (r_idx == END_IDX) begin
                    r_ovr <= 1'b1;
                end else begin
                    r_idx     <= r_idx + 9'd1;
                    r_wr_data <= record_word(r_idx + 9'd1, r_hi, r_wcnt);
                end
            end
        end else begin
            r_idx     <= '0;
            r_ovr     <= 1'b0;
            r_wr_data <= MAGIC;
        end
    end

    assign wr_sec_addr  = SCORE_SEC_ADDR;
    assign wr_data      = r_wr_data;
    assign hi_score_bcd = r_hi;
    assign save_err     = r_err;

endmodule

// File: tb/tb_sd_score_writer.sv
// Directed bench: a table of save scenarios against a behavioural SD write
// port, plus hand sequences for port gating and reset during a write.
module tb_sd_score_writer;

    localparam int START_TO = 1000;

    logic        clk_50m = 1'b0;
    logic        rst_n;
    logic [1:0]  game_state;
    logic [23:0] score_bcd;
    logic        sd_init_done;
    logic        pic_load_done;
    logic        wr_busy;
    logic        wr_req;
    logic        wr_start_en;
    logic [31:0] wr_sec_addr;
    logic [15:0] wr_data;
    logic [23:0] hi_score_bcd;
    logic        save_busy;
    logic        save_done;
    logic        save_err;

    sd_score_writer #(.START_TO(START_TO)) dut (
        .clk_50m       (clk_50m),
        .rst_n         (rst_n),
        .game_state    (game_state),
        .score_bcd     (score_bcd),
        .sd_init_done  (sd_init_done),
        .pic_load_done (pic_load_done),
        .wr_busy       (wr_busy),
        .wr_req        (wr_req),
        .wr_start_en   (wr_start_en),
        .wr_sec_addr   (wr_sec_addr),
        .wr_data       (wr_data),
        .hi_score_bcd  (hi_score_bcd),
        .save_busy     (save_busy),
        .save_done     (save_done),
        .save_err      (save_err)
    );

    always #10 clk_50m = ~clk_50m;

    typedef struct {
        logic [23:0] score;
        int          nreq;
        bit          respond;
        bit          exp_start;
        bit          exp_done;
        bit          exp_err;
        logic [23:0] exp_hi;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t        tbl[6];
    int          n_chk = 0;
    int          n_err = 0;
    int          n_start = 0;
    logic [15:0] rec[5];
    logic [15:0] last_word;

    always @(posedge clk_50m) if (wr_start_en === 1'b1) n_start <= n_start + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input int i, input logic [23:0] s, input logic [15:0] c);
        logic [15:0] w0, w1, w2;
        w0 = 16'h4642;
        w1 = {8'h00, s[23:16]};
        w2 = s[15:0];
        if (i == 0) return w0;
        if (i == 1) return w1;
        if (i == 2) return w2;
        if (i == 3) return c;
        if (i == 4) return w0 ^ w1 ^ w2 ^ c;
        return 16'h0000;
    endfunction

    task automatic go_over(input logic [23:0] s);
        game_state = 2'd1;
        repeat (4) @(negedge clk_50m);
        score_bcd = s;
        repeat (4) @(negedge clk_50m);
        game_state = 2'd2;
    endtask

    // Controller model: raise busy, issue nreq wr_req pulses 17 cycles apart.
    task automatic ctrl_write(input int nreq, input logic [23:0] s, input logic [15:0] c,
                              input bit drop, input string nm);
        int bad;
        bad = 0;
        repeat (3) @(negedge clk_50m);
        wr_busy = 1'b1;
        for (int i = 0; i < nreq; i++) begin
            repeat (16) @(negedge clk_50m);
            if (i < 5) rec[i] = wr_data;
            last_word = wr_data;
            if (wr_data !== exp_word(i, s, c)) bad++;
            wr_req = 1'b1;
            @(negedge clk_50m);
            wr_req = 1'b0;
        end
        check({nm, "_words_bad"}, bad, 0);
        if (drop) begin
            repeat (3) @(negedge clk_50m);
            wr_busy = 1'b0;
        end
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (save_busy && k < 100) begin @(negedge clk_50m); k++; end
        check({nm, "_idle_reached"}, save_busy, 0);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int k, busy_cyc, n0;
        n0 = n_start;
        go_over(v.score);
        k = 0;
        busy_cyc = 0;
        while (!wr_start_en && k < 40) begin
            @(negedge clk_50m);
            k++;
            if (save_busy) busy_cyc++;
        end
        check({nm, "_start_seen"}, wr_start_en, v.exp_start);
        if (!v.exp_start)
            check({nm, "_busy_len_ok"}, (busy_cyc >= 1 && busy_cyc <= 20), 1);
        if (v.exp_start && wr_start_en) begin
            if (!v.respond) begin
                k = 0;
                while (!save_err && k < START_TO + 100) begin @(negedge clk_50m); k++; end
                check({nm, "_start_to_cycles"}, k, START_TO + 1);
            end else begin
                ctrl_write(v.nreq, v.score, v.exp_cnt, 1'b1, nm);
                @(negedge clk_50m);
                check({nm, "_done_pulse"}, save_done, v.exp_done);
                check({nm, "_err_at_end"}, save_err, v.exp_err);
            end
        end
        wait_idle(nm);
        check({nm, "_start_count"}, n_start - n0, v.exp_start ? 1 : 0);
        check({nm, "_hi"}, hi_score_bcd, v.exp_hi);
        check({nm, "_err_sticky"}, save_err, v.exp_err);
        game_state = 2'd0;
        repeat (4) @(negedge clk_50m);
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_start_en"}, wr_start_en, 0);
        check({nm, "_wr_data"}, wr_data, 16'h4642);
        check({nm, "_hi"}, hi_score_bcd, 0);
        check({nm, "_busy"}, save_busy, 0);
        check({nm, "_done"}, save_done, 0);
        check({nm, "_err"}, save_err, 0);
        check({nm, "_sec_addr"}, wr_sec_addr, 32'd32768);
    endtask

    initial begin
        int   k, n0;
        vec_t v;

        tbl[0] = '{24'h000042, 256, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000042, 16'd1};
        tbl[1] = '{24'h000017, 0,   1'b1, 1'b0, 1'b0, 1'b0, 24'h000042, 16'd1};
        tbl[2] = '{24'h000100, 0,   1'b0, 1'b1, 1'b0, 1'b1, 24'h000100, 16'd2};
        tbl[3] = '{24'h000150, 256, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000150, 16'd3};
        tbl[4] = '{24'h000200, 200, 1'b1, 1'b1, 1'b0, 1'b1, 24'h000200, 16'd4};
        tbl[5] = '{24'h000300, 257, 1'b1, 1'b1, 1'b0, 1'b1, 24'h000300, 16'd5};

        rst_n = 1'b0; game_state = 2'd0; score_bcd = '0;
        sd_init_done = 1'b1; pic_load_done = 1'b1; wr_busy = 1'b0; wr_req = 1'b0;
        repeat (3) @(negedge clk_50m);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk_50m);

        for (int i = 0; i < 6; i++) begin
            run_vec(tbl[i], $sformatf("v%0d", i));
            if (i == 0) begin
                check("v0_word3", rec[3], 16'h0001);
                check("v0_word4", rec[4], 16'h4601);
            end
            if (i == 5) check("v5_overrun_word", last_word, 16'h0000);
        end

        // Port gating: request held off until pic_load_done.
        pic_load_done = 1'b0;
        n0 = n_start;
        go_over(24'h000400);
        repeat (50) @(negedge clk_50m);
        check("gate_no_start", n_start - n0, 0);
        check("gate_busy", save_busy, 1);
        pic_load_done = 1'b1;
        k = 0;
        while (!wr_start_en && k < 5) begin @(negedge clk_50m); k++; end
        check("gate_start_lat", (k >= 1 && k <= 2), 1);
        if (wr_start_en) begin
            ctrl_write(256, 24'h000400, 16'd6, 1'b1, "gate");
            @(negedge clk_50m);
            check("gate_done", save_done, 1);
        end
        wait_idle("gate");
        check("gate_hi", hi_score_bcd, 24'h000400);
        check("gate_err", save_err, 0);
        game_state = 2'd0;
        repeat (4) @(negedge clk_50m);

        // Reset at word 100 of a write.
        go_over(24'h000500);
        k = 0;
        while (!wr_start_en && k < 40) begin @(negedge clk_50m); k++; end
        check("rstw_start_seen", wr_start_en, 1);
        ctrl_write(100, 24'h000500, 16'd7, 1'b0, "rstw");
        check("rstw_busy_before", save_busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rstw_async");
        game_state = 2'd0;
        wr_busy = 1'b0;
        repeat (3) @(negedge clk_50m);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_50m);
        v = '{24'h000005, 256, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000005, 16'd1};
        run_vec(v, "post_rst");
        check("post_rst_word3", rec[3], 16'h0001);
        check("post_rst_word2", rec[2], 16'h0005);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sd_score_writer.md
# sd_score_writer

Persists the Flappy Bird high score to a fixed SD card sector. It watches the game state for entry into OVER and compares the final BCD score against the stored high score. On a new record it drives the write port of `sd_ctrl_top` (`wr_start_en`/`wr_sec_addr`/`wr_req`/`wr_data`/`wr_busy`) with one 512-byte record sector. It sits beside `sd_multi_pic`, which owns the read port of the same controller, and runs in the `clk_50m` domain.

## Interface
- `SCORE_SEC_ADDR`, 32'd32768: sector written.
- `MAGIC`, 16'h4642: record word 0 ("FB").
- `SEC_WORDS`, 256: 16-bit words per sector.
- `START_TO`, 1000: max cycles from `wr_start_en` to `wr_busy` rising.
- `BUSY_TO`, 10_000_000: max cycles `wr_busy` may stay high (200 ms).
- `clk_50m` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `game_state` in 2: from `game_ctrl` (hdmi_clk domain); 0 IDLE, 1 PLAY, 2 OVER.
- `score_bcd` in 24: 6-digit BCD (hdmi_clk domain), stable while OVER.
- `sd_init_done` in 1: SD controller ready.
- `pic_load_done` in 1: `sd_multi_pic` finished; SD read port idle.
- `wr_busy` in 1: controller write in progress.
- `wr_req` in 1: one-cycle pulse; controller consumes `wr_data` this cycle.
- `wr_start_en` out 1: one-cycle write start pulse.
- `wr_sec_addr` out 32: constant `SCORE_SEC_ADDR`.
- `wr_data` out 16: current record word.
- `hi_score_bcd` out 24: best score so far.
- `save_busy` out 1: high from CAPTURE through DONE/ERR.
- `save_done` out 1: one-cycle pulse on successful write.
- `save_err` out 1: sticky; cleared on the next accepted save request.

## Operation
- **CDC.** `game_state` and `score_bcd` each pass through a 2-FF synchronizer. The request is the synchronized `game_state` changing to 2 from any other value.
- **States.**
  - IDLE: waits for a request. A request arriving while not IDLE is ignored.
  - CAPTURE: loads the synchronized score once it reads identical on 2 consecutive cycles (max 16 cycles, else use the last sample). Compares it unsigned against `hi_score_bcd`; valid BCD preserves numeric order.
    - Score ≤ hi: back to IDLE, with no `save_done` and no write.
    - Score > hi: update `hi_score_bcd` and `write_cnt`, then WAIT_PORT.
  - WAIT_PORT: waits for `sd_init_done & pic_load_done & ~wr_busy`.
  - START: `wr_start_en`=1 for exactly 1 cycle, then WAIT_BUSY.
  - WAIT_BUSY: `wr_busy` rising → STREAM; `START_TO` expiry → ERR.
  - STREAM: each `wr_req` increments `idx` (9 bits). `wr_busy` falling → DONE if `idx`==`SEC_WORDS`, else ERR. `BUSY_TO` expiry → ERR.
  - DONE / ERR: `save_done` or `save_err` asserted, then IDLE.
- **Record.**
  - Word 0: `MAGIC`.
  - Word 1: {8'h00, score[23:16]}.
  - Word 2: score[15:0].
  - Word 3: `write_cnt`, 16-bit, wrapping at 16'hFFFF→0.
  - Word 4: XOR of words 0–3.
  - Words 5–255: 16'h0000.
- **Excess `wr_req`.** Any `wr_req` with `idx`==`SEC_WORDS` gets `wr_data`=0, sets the overrun flag, and the save ends in ERR.
- **`hi_score_bcd` on failure.** It is not rolled back on ERR. The in-RAM record remains valid.
- **Reset.** Reset mid-write drops all state immediately. `wr_start_en` goes low and the partially written sector is left as-is.

## Timing
- **Reset values.**
  - `wr_start_en`=0, `wr_data`=`MAGIC`, `hi_score_bcd`=0.
  - `save_busy`=0, `save_done`=0, `save_err`=0.
  - `write_cnt`=0, `idx`=0.
  - `wr_sec_addr`=`SCORE_SEC_ADDR` always.
- **Data presentation.** `wr_data` is registered. Word 0 is valid before `wr_start_en`. On the edge after a `wr_req` cycle, `wr_data` holds word `idx`+1. The controller spaces `wr_req` pulses at least 16 cycles apart.
- **Request latency.** OVER entry in hdmi_clk → IDLE leaves within 3 + 2..16 cycles.
- **Start latency.** `wr_start_en` follows WAIT_PORT exit by 1 cycle.
- **Completion.** `save_done` is asserted 1 cycle after `wr_busy` falls.
- **Timeouts.** Counters are 24 bits, cleared on every state entry.

## Structure
- Package `sd_score_pkg`:
  - State enum.
  - `MAGIC`.
  - Record word offsets (0–4).
  - `SEC_WORDS`.
- Sub-module `sd_score_sync`: 2-FF synchronizer bank plus state-change detector for `game_state`/`score_bcd`.

## Test plan
- **New record.** OVER with score 000042, hi 0 → one `wr_start_en`, 256 words: 4642, 0000, 0042, 0001, 4601, then zeros. `save_done` pulse, `hi_score_bcd`=000042.
- **Not a record.** Second OVER with score 000017 → no `wr_start_en`, `hi_score_bcd` stays 000042, `save_busy` ≤ 20 cycles.
- **Port gating.** Request while `pic_load_done`=0 → no `wr_start_en` until `pic_load_done` rises, then a write within 2 cycles.
- **Start timeout.** Controller never raises `wr_busy` → `save_err`=1 at `START_TO`+1 cycles. The next record save clears it and succeeds.
- **Short sector.** `wr_busy` falls after 200 `wr_req` → ERR. Separately, 257 `wr_req` → `wr_data`=0 on the last word and ERR.
- **Reset mid-write.** Assert `rst_n`=0 at word 100 → all outputs return to reset values asynchronously. After release, a new OVER with score 000005 writes `write_cnt`=1.
